// File: rtl/level_monitor_multi_pkg.sv
// Shared types and helpers for the multi-channel level monitor: FSM state encoding,
// thermometer-code validation and popcount, and the reset value of the low threshold.
package level_pkg;

   localparam int MAX_W      = 32;
   localparam int TH_LOW_RST = 1;   // high threshold resets to SENSOR_W, which is a module parameter

   typedef enum logic [1:0] {
      ST_NORMAL,
      ST_HIGH,
      ST_LOW,
      ST_FAULT
   } state_e;

   function automatic int popcount(input logic [MAX_W-1:0] x);
      int n;
      n = 0;
      for (int i = 0; i < MAX_W; i++) n += int'(x[i]);
      return n;
   endfunction

   // Nonzero and of the form 0..01..1: adding one to a run of LSB ones clears every set bit.
   function automatic logic thermo_valid(input logic [MAX_W-1:0] x);
      return (x != '0) && ((x & (x + 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/level_monitor_multi_if.sv
// Pad-side bundle of the level monitor: sensor/setup/button inputs and the display/LED outputs.
// master = stimulus/pad side, slave = the monitor core.
interface level_monitor_multi_if #(
   parameter int SENSOR_W = 8,
   parameter int CHANNELS = 2
);
   localparam int LVL_W = $clog2(SENSOR_W + 1);
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS*SENSOR_W-1:0] sensors_input;
   logic [SENSOR_W-1:0]          setup_input;
   logic [CH_W-1:0]              ch_sel;
   logic                         saveH_button;
   logic                         saveL_button;
   logic                         ack_button;
   logic [CHANNELS*LVL_W-1:0]    level_out;
   logic [CHANNELS-1:0]          level_valid;
   logic [CHANNELS-1:0]          alarm_high;
   logic [CHANNELS-1:0]          alarm_low;
   logic [CHANNELS-1:0]          fault;
   logic                         setup_error;

   modport master (
      output sensors_input, setup_input, ch_sel, saveH_button, saveL_button, ack_button,
      input  level_out, level_valid, alarm_high, alarm_low, fault, setup_error
   );

   modport slave (
      input  sensors_input, setup_input, ch_sel, saveH_button, saveL_button, ack_button,
      output level_out, level_valid, alarm_high, alarm_low, fault, setup_error
   );
endinterface

// File: rtl/level_monitor_multi_debouncer.sv
// Raw push-button conditioner: 2-FF synchroniser, stability counter, and a one-cycle
// pulse on each rising edge of the debounced level.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_rise
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]       r_sync;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_sync   <= 2'b00;
         r_stable <= 1'b0;
         r_cnt    <= '0;
         o_rise   <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_btn};
         o_rise <= 1'b0;
         if (r_sync[1] == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= r_sync[1];
            r_cnt    <= '0;
            o_rise   <= r_sync[1];
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/level_monitor_multi.sv
// Multi-channel tank level monitor: per-channel sample filter, thermometer decode and alarm FSM
// with hysteresis, plus button-driven threshold setup. `define ALARM_LATCH_EN for sticky, ack-cleared alarms.
module level_monitor_multi
   import level_pkg::*;
#(
   parameter int SENSOR_W        = 8,
   parameter int CHANNELS        = 2,
   parameter int STABLE_CYCLES   = 1000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HYST            = 1
) (
   input  logic                 clk_100MHz,
   input  logic                 reset_n,
   level_monitor_multi_if.slave bus
);
   localparam int LVL_W = $clog2(SENSOR_W + 1);
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

   // Reset asserts asynchronously but is released on a clock edge.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   logic w_h_rise, w_l_rise;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_h (
      .clk(clk_100MHz), .rst_n(w_rst_n), .i_btn(bus.saveH_button), .o_rise(w_h_rise));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
      .clk(clk_100MHz), .rst_n(w_rst_n), .i_btn(bus.saveL_button), .o_rise(w_l_rise));

`ifdef ALARM_LATCH_EN
   logic w_ack_rise;
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ack (
      .clk(clk_100MHz), .rst_n(w_rst_n), .i_btn(bus.ack_button), .o_rise(w_ack_rise));
`else
   logic w_unused_ack;
   assign w_unused_ack = bus.ack_button;
`endif

   logic [LVL_W-1:0] r_th_high [CHANNELS];
   logic [LVL_W-1:0] r_th_low  [CHANNELS];
   logic [LVL_W-1:0] w_set_lvl, w_sel_high, w_sel_low;
   logic             w_set_ok, w_sel_ok, w_do_h, w_do_l, w_err;
   logic             r_setup_error;

   always_comb begin
      // NOTE: every comb output is given a default first so no path leaves it unassigned and infers a latch.
      w_set_lvl  = LVL_W'(popcount(MAX_W'(bus.setup_input)));
      w_set_ok   = thermo_valid(MAX_W'(bus.setup_input));
      w_sel_ok   = int'(bus.ch_sel) < CHANNELS;
      w_sel_high = '0;
      w_sel_low  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (CH_W'(c) == bus.ch_sel) begin
            w_sel_high = r_th_high[c];
            w_sel_low  = r_th_low[c];
         end
      end
      w_do_h = 1'b0;
      w_do_l = 1'b0;
      w_err  = 1'b0;
      if (w_h_rise && w_l_rise) begin
         w_err = 1'b1;
      end else if (w_h_rise) begin
         if (w_sel_ok && w_set_ok && (w_set_lvl > w_sel_low)) w_do_h = 1'b1;
         else                                                 w_err  = 1'b1;
      end else if (w_l_rise) begin
         if (w_sel_ok && w_set_ok && (w_set_lvl < w_sel_high)) w_do_l = 1'b1;
         else                                                  w_err  = 1'b1;
      end
   end

   always_ff @(posedge clk_100MHz or negedge w_rst_n) begin
      if (!w_rst_n) begin
         // NOTE: the threshold array is tiny and must restart at known limits, so it is reset like plain flops.
         for (int c = 0; c < CHANNELS; c++) begin
            r_th_high[c] <= LVL_W'(SENSOR_W);
            r_th_low[c]  <= LVL_W'(TH_LOW_RST);
         end
         r_setup_error <= 1'b0;
      end else begin
         r_setup_error <= w_err;
         for (int c = 0; c < CHANNELS; c++) begin
            if (CH_W'(c) == bus.ch_sel) begin
               if (w_do_h) r_th_high[c] <= w_set_lvl;
               if (w_do_l) r_th_low[c]  <= w_set_lvl;
            end
         end
      end
   end
   assign bus.setup_error = r_setup_error;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [SENSOR_W-1:0] w_word, r_prev;
      logic [CNT_W-1:0]    r_cnt;
      logic [LVL_W-1:0]    r_level;
      logic                w_accept, r_valid, r_acc_ok, r_acc_bad;
      logic                w_hi, w_lo, w_flt, r_hi, r_lo, r_flt;
      state_e              r_state, w_next;

      assign w_word   = bus.sensors_input[c*SENSOR_W +: SENSOR_W];
      assign w_accept = (w_word == r_prev) && (r_cnt == CNT_W'(STABLE_CYCLES - 1));

      // Counter saturates one past the accept point so a held word is accepted only once.
      always_ff @(posedge clk_100MHz or negedge w_rst_n) begin
         if (!w_rst_n) begin
            r_prev    <= '0;
            r_cnt     <= '0;
            r_level   <= '0;
            r_valid   <= 1'b0;
            r_acc_ok  <= 1'b0;
            r_acc_bad <= 1'b0;
         end else begin
            r_prev    <= w_word;
            r_acc_ok  <= 1'b0;
            r_acc_bad <= 1'b0;
            if (w_word != r_prev)                     r_cnt <= '0;
            else if (r_cnt < CNT_W'(STABLE_CYCLES)) r_cnt <= r_cnt + 1'b1;
            if (w_accept) begin
               if (thermo_valid(MAX_W'(w_word))) begin
                  r_level  <= LVL_W'(popcount(MAX_W'(w_word)));
                  r_valid  <= 1'b1;
                  r_acc_ok <= 1'b1;
               end else begin
                  r_valid   <= 1'b0;
                  r_acc_bad <= 1'b1;
               end
            end
         end
      end

      always_ff @(posedge clk_100MHz or negedge w_rst_n) begin
         if (!w_rst_n) begin
            r_state <= ST_NORMAL;
            r_hi    <= 1'b0;
            r_lo    <= 1'b0;
            r_flt   <= 1'b0;
         end else begin
            r_state <= w_next;
            r_hi    <= w_hi;
            r_lo    <= w_lo;
            r_flt   <= w_flt;
         end
      end

      // Thresholds are only compared once a valid level exists, so the reset level of 0 raises no alarm.
      always_comb begin
         int hi_exit, lo_exit;
         hi_exit = (int'(r_th_high[c]) > HYST) ? int'(r_th_high[c]) - HYST : 0;
         lo_exit = int'(r_th_low[c]) + HYST;
         w_next  = r_state;
         if (r_acc_bad) begin
            w_next = ST_FAULT;
         end else begin
            case (r_state)
               ST_NORMAL: if (r_valid) begin
                  if (r_level >= r_th_high[c])     w_next = ST_HIGH;
                  else if (r_level <= r_th_low[c]) w_next = ST_LOW;
               end
               ST_HIGH:   if (int'(r_level) < hi_exit) w_next = ST_NORMAL;
               ST_LOW:    if (int'(r_level) > lo_exit) w_next = ST_NORMAL;
               ST_FAULT:  if (r_acc_ok)                w_next = ST_NORMAL;
               default:   w_next = ST_NORMAL;
            endcase
         end
      end

      always_comb begin
`ifdef ALARM_LATCH_EN
         logic clr;
         clr   = w_ack_rise && (r_state == ST_NORMAL);
         w_hi  = (r_hi  && !clr) || (w_next == ST_HIGH);
         w_lo  = (r_lo  && !clr) || (w_next == ST_LOW);
         w_flt = (r_flt && !clr) || (w_next == ST_FAULT);
`else
         w_hi  = (w_next == ST_HIGH);
         w_lo  = (w_next == ST_LOW);
         w_flt = (w_next == ST_FAULT);
`endif
      end

      assign bus.level_out[c*LVL_W +: LVL_W] = r_level;
      assign bus.level_valid[c]              = r_valid;
      assign bus.alarm_high[c]               = r_hi;
      assign bus.alarm_low[c]                = r_lo;
      assign bus.fault[c]                    = r_flt;
   end
endmodule
